ysyx_25040105_lsu: RTL
======================

// Module: ysyx_25040105_lsu
// PURPOSE
//  Load/store unit directly downstream of the EXU. Takes the EXU's effective address, store data and
//  load/store op, runs one multi-cycle access on a valid/ready memory bus, and returns the extended
//  load result to write-back. It replaces the combinational DPI memory calls in the execute stage.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles in WAIT before forced error completion; 0 disables the timeout
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst_n          in   1   asynchronous reset, active low
//  in_valid       in   1   EXU request valid
//  in_ready       out  1   LSU can accept a request
//  in_op          in   8   EXU op: LB 1D, LH 1E, LW 1F, LBU 20, LHU 21, SB 22, SH 23, SW 24
//  in_addr        in   32  effective address rs1+imm (from EXU)
//  in_wdata       in   32  store data (rs2), LSBs used for SB/SH
//  out_valid      out  1   result valid to write-back
//  out_ready      in   1   write-back accepts result
//  out_rdata      out  32  extended load data; 0 for stores, errors and non-LS ops
//  out_err        out  1   misaligned access, bus error or timeout
//  mem_req_valid  out  1   bus request valid
//  mem_req_ready  in   1   bus accepts request
//  mem_req_wen    out  1   1 = write
//  mem_req_addr   out  32  word-aligned address {addr[31:2],2'b00}
//  mem_req_wdata  out  32  store data shifted to byte lane
//  mem_req_wmask  out  4   byte enables; 4'b0000 for reads
//  mem_resp_valid in   1   bus response (read data or write ack), single-cycle pulse
//  mem_resp_rdata in   32  aligned read word
//  mem_resp_err   in   1   bus error flag, qualified by mem_resp_valid
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_err=0, out_rdata=0, mem_req_valid=0, timer=0.
//  FSM IDLE->REQ->WAIT->DONE->IDLE. in_ready is 1 only in IDLE.
//  IDLE: accept on in_valid&in_ready and latch op, addr, wdata.
//   - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go DONE, err=1, no bus access.
//   - Op outside 1D..24: go DONE, err=0, rdata=0, no bus access.
//   - Otherwise go REQ.
//  REQ: mem_req_valid=1. Address, wdata, wmask and wen are held stable until mem_req_ready.
//   - On handshake go WAIT and clear the timer.
//  WAIT: mem_req_valid=0; timer increments each cycle.
//   - On mem_resp_valid go DONE, err=mem_resp_err.
//   - If timer reaches TIMEOUT_CYC (nonzero) first, go DONE with err=1.
//   - A response is never taken in the same cycle as the request handshake.
//  DONE: out_valid=1; out_rdata and out_err are held until out_ready, then return to IDLE.
//   - There is no IDLE bypass: a new request is accepted one cycle after DONE exits.
//  Latency: accept at T, req at T+1; with ready=1 and a 1-cycle response, out_valid at T+3.
//   - Misaligned or non-LS op: out_valid at T+1.
//  Store lanes, o = addr[1:0]:
//   - SB: wmask=4'b0001<<o, wdata=wdata[7:0]<<8*o
//   - SH: wmask=o[1]?1100:0011, wdata=wdata[15:0]<<16*o[1]
//   - SW: wmask=1111, wdata unchanged
//  Load extraction from mem_resp_rdata, captured in the response cycle:
//   - LB/LBU: byte o, sign- or zero-extended
//   - LH/LHU: half o[1], sign- or zero-extended
//   - LW: full word
//  On err, out_rdata=0 and loaded data is discarded.
//  Async reset mid-operation drops mem_req_valid and out_valid immediately and returns to IDLE.
//   - A late mem_resp_valid arriving in IDLE is ignored.
// TESTING
//  - LW addr 0x80000008, bus word 0xDEADBEEF, ready=1, 1-cycle resp -> out_valid at T+3,
//    rdata=0xDEADBEEF, err=0.
//  - LB addr 0x80000003, word 0x80112233 -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
//  - SB addr 0x80000002, wdata 0x000000AB -> req addr 0x80000000, wmask 0100, wdata 0x00AB0000, wen=1.
//  - LW addr 0x80000006 -> no mem_req_valid; out_valid at T+1, err=1, rdata=0.
//  - mem_req_ready low 3 cycles, then out_ready low 2 cycles in DONE -> req fields and out fields
//    stable throughout; in_ready=0 until IDLE.
//  - TIMEOUT_CYC=4 with no response -> err=1 after 4 WAIT cycles.
//  - rst_n pulsed during WAIT -> all outputs return to reset values at once; the later response
//    is ignored.

Source files
------------

// File: rtl/ysyx_25040105_lsu_if.sv
// LSU bus bundle: EXU request, write-back result and memory bus.
// slave is the LSU view; master is the EXU/memory side.
interface ysyx_25040105_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata,
    output in_ready,
    output out_valid, out_rdata, out_err,
    input  out_ready,
    output mem_req_valid, mem_req_wen,
    output mem_req_addr, mem_req_wdata,
    output mem_req_wmask,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata,
    input  mem_resp_err
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata,
    input  in_ready,
    input  out_valid, out_rdata, out_err,
    output out_ready,
    input  mem_req_valid, mem_req_wen,
    input  mem_req_addr, mem_req_wdata,
    input  mem_req_wmask,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata,
    output mem_resp_err
  );
endinterface

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: one multi-cycle access per EXU request
// over a valid/ready memory bus, extended result to WB.
module ysyx_25040105_lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_25040105_lsu_if.slave bus
);
  localparam logic [7:0] OP_LB  = 8'h1D;
  localparam logic [7:0] OP_LH  = 8'h1E;
  localparam logic [7:0] OP_LW  = 8'h1F;
  localparam logic [7:0] OP_LBU = 8'h20;
  localparam logic [7:0] OP_LHU = 8'h21;
  localparam logic [7:0] OP_SB  = 8'h22;
  localparam logic [7:0] OP_SH  = 8'h23;
  localparam logic [7:0] OP_SW  = 8'h24;
  localparam logic       TO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TO_M1  = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  timer_q, timer_d;

  logic        in_ls, in_mis;
  logic [1:0]  o;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        is_st;

  always_comb begin
    in_ls  = (bus.in_op >= OP_LB) &&
             (bus.in_op <= OP_SW);
    in_mis = ((bus.in_op == OP_LH) ||
              (bus.in_op == OP_LHU) ||
              (bus.in_op == OP_SH)) &&
             bus.in_addr[0];
    if (((bus.in_op == OP_LW) ||
         (bus.in_op == OP_SW)) &&
        (bus.in_addr[1:0] != 2'b00))
      in_mis = 1'b1;
  end

  assign o = addr_q[1:0];

  always_comb begin
    is_st   = 1'b1;
    st_mask = 4'b0000;
    st_data = 32'h0;
    unique case (1'b1)
      (op_q == OP_SB): begin
        st_mask = 4'b0001 << o;
        st_data = {24'h0, wdata_q[7:0]} << {o, 3'b000};
      end
      (op_q == OP_SH): begin
        st_mask = o[1] ? 4'b1100 : 4'b0011;
        st_data = o[1] ? {wdata_q[15:0], 16'h0}
                       : {16'h0, wdata_q[15:0]};
      end
      (op_q == OP_SW): begin
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
      default: is_st = 1'b0;
    endcase
  end

  always_comb begin
    case (o)
      2'd0:    byte_v = bus.mem_resp_rdata[7:0];
      2'd1:    byte_v = bus.mem_resp_rdata[15:8];
      2'd2:    byte_v = bus.mem_resp_rdata[23:16];
      default: byte_v = bus.mem_resp_rdata[31:24];
    endcase
    half_v = o[1] ? bus.mem_resp_rdata[31:16]
                  : bus.mem_resp_rdata[15:0];
    ld_val = 32'h0;
    unique case (1'b1)
      (op_q == OP_LB):
        ld_val = {{24{byte_v[7]}}, byte_v};
      (op_q == OP_LBU):
        ld_val = {24'h0, byte_v};
      (op_q == OP_LH):
        ld_val = {{16{half_v[15]}}, half_v};
      (op_q == OP_LHU):
        ld_val = {16'h0, half_v};
      (op_q == OP_LW):
        ld_val = bus.mem_resp_rdata;
      default: ld_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        op_d    = bus.in_op;
        addr_d  = bus.in_addr;
        wdata_d = bus.in_wdata;
        rdata_d = 32'h0;
        err_d   = 1'b0;
        if (!in_ls) begin
          state_d = DONE;
        end else if (in_mis) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      REQ: if (bus.mem_req_ready) begin
        state_d = WAIT;
        timer_d = 8'h0;
      end
      WAIT: begin
        timer_d = timer_q + 8'h1;
        if (bus.mem_resp_valid) begin
          state_d = DONE;
          err_d   = bus.mem_resp_err;
          rdata_d = bus.mem_resp_err ? 32'h0 : ld_val;
        end else if (TO_EN && (timer_q == TO_M1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      default: if (bus.out_ready) begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 8'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      timer_q <= 8'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_rdata     = rdata_q;
  assign bus.out_err       = err_q;
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_wen   = is_st;
  assign bus.mem_req_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_req_wdata = st_data;
  assign bus.mem_req_wmask = st_mask;
endmodule
